// File: rtl/jtag_board_loader.sv
// Receive-side parser for the JTAG UART link: turns an ASCII cell stream into 8x8 boards
// handed to the game_of_life load path. Optional echo port enabled by BOARD_ECHO_EN.
module jtag_board_loader #(
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [63:0] board_data,
    output logic        board_valid,
    input  logic        board_ready,
    output logic [7:0]  frame_count,
    output logic [3:0]  err_count
`ifdef BOARD_ECHO_EN
    ,
    output logic [7:0]  echo_data,
    output logic        echo_valid
`endif
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_COLLECT = 2'd1, ST_HOLD = 2'd2} state_e;
    typedef enum logic [2:0] {
        CLS_ALIVE = 3'd0, CLS_DEAD = 3'd1, CLS_SKIP = 3'd2, CLS_ABORT = 3'd3, CLS_ILLEGAL = 3'd4
    } cls_e;

    function automatic cls_e classify(input logic [7:0] b);
        case (b)
            8'h31, 8'h23, 8'h4F, 8'h6F: classify = CLS_ALIVE;
            8'h30, 8'h2E:               classify = CLS_DEAD;
            8'h0A, 8'h0D, 8'h20:        classify = CLS_SKIP;
            8'h1B:                      classify = CLS_ABORT;
            default:                    classify = CLS_ILLEGAL;
        endcase
    endfunction

    state_e            state_q, state_d;
    logic [5:0]        cell_idx_q, cell_idx_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [63:0]       shadow_q, shadow_d;
    logic [63:0]       board_q, board_d;
    logic              valid_q, valid_d;
    logic [7:0]        frame_q, frame_d;
    logic [3:0]        err_q, err_d;
    logic [7:0]        echo_data_q, echo_data_d;
    logic              echo_valid_q, echo_valid_d;

    cls_e cls_s;
    logic accept_s, cell_s, timeout_s, last_cell_s;

    assign rx_ready    = !reset && (state_q != ST_HOLD);
    assign accept_s    = rx_valid && rx_ready;
    assign cls_s       = classify(rx_data);
    assign cell_s      = accept_s && ((cls_s == CLS_ALIVE) || (cls_s == CLS_DEAD));
    // An accepted byte on the expiry cycle always beats the timeout.
    assign timeout_s   = (state_q == ST_COLLECT) && !accept_s && (to_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign last_cell_s = cell_s && (state_q == ST_COLLECT) && (cell_idx_q == 6'd63);

    assign board_data  = board_q;
    assign board_valid = valid_q;
    assign frame_count = frame_q;
    assign err_count   = err_q;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cell_idx_q   <= 6'd0;
            to_q         <= '0;
            shadow_q     <= 64'd0;
            board_q      <= 64'd0;
            valid_q      <= 1'b0;
            frame_q      <= 8'd0;
            err_q        <= 4'd0;
            echo_data_q  <= 8'd0;
            echo_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cell_idx_q   <= cell_idx_d;
            to_q         <= to_d;
            shadow_q     <= shadow_d;
            board_q      <= board_d;
            valid_q      <= valid_d;
            frame_q      <= frame_d;
            err_q        <= err_d;
            echo_data_q  <= echo_data_d;
            echo_valid_q <= echo_valid_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cell_s) begin
                    state_d = ST_COLLECT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (last_cell_s) begin
                    state_d = ST_HOLD;
                end else if (accept_s && ((cls_s == CLS_ILLEGAL) || (cls_s == CLS_ABORT))) begin
                    state_d = ST_IDLE;
                end else if (timeout_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_HOLD: begin
                if (valid_q && board_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath, counters and echo next values.
    always_comb begin
        cell_idx_d   = cell_idx_q;
        to_d         = '0;
        shadow_d     = shadow_q;
        board_d      = board_q;
        valid_d      = valid_q;
        frame_d      = frame_q;
        err_d        = err_q;
        echo_data_d  = 8'd0;
        echo_valid_d = 1'b0;

        if (cell_s) begin
            shadow_d[cell_idx_q] = (cls_s == CLS_ALIVE);
            cell_idx_d           = cell_idx_q + 6'd1;
        end else if (accept_s && ((cls_s == CLS_ILLEGAL) || (cls_s == CLS_ABORT))) begin
            cell_idx_d = 6'd0;
        end else if (timeout_s) begin
            cell_idx_d = 6'd0;
        end else begin
            cell_idx_d = cell_idx_q;
        end

        if ((state_q == ST_COLLECT) && !accept_s && !timeout_s) begin
            to_d = to_q + TO_W'(1);
        end else begin
            to_d = '0;
        end

        if ((accept_s && (cls_s == CLS_ILLEGAL)) || timeout_s) begin
            err_d = (err_q == 4'd15) ? err_q : (err_q + 4'd1);
        end else begin
            err_d = err_q;
        end

        if (last_cell_s) begin
            board_d = shadow_d;
            valid_d = 1'b1;
            frame_d = frame_q + 8'd1;
        end else if ((state_q == ST_HOLD) && valid_q && board_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        if (accept_s && (cls_s != CLS_ABORT)) begin
            echo_valid_d = 1'b1;
            case (cls_s)
                CLS_ALIVE: echo_data_d = 8'h23;
                CLS_DEAD:  echo_data_d = 8'h2E;
                CLS_SKIP:  echo_data_d = rx_data;
                default:   echo_data_d = 8'h3F;
            endcase
        end else if (timeout_s) begin
            echo_valid_d = 1'b1;
            echo_data_d  = 8'h3F;
        end else begin
            echo_valid_d = 1'b0;
            echo_data_d  = 8'd0;
        end
    end

`ifdef BOARD_ECHO_EN
    assign echo_data  = echo_data_q;
    assign echo_valid = echo_valid_q;
`else
    logic unused_echo_s;
    assign unused_echo_s = ^{echo_data_q, echo_valid_q};
`endif

endmodule

// File: tb/tb_jtag_board_loader.sv
// Self-checking bench for jtag_board_loader: directed test-plan scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_jtag_board_loader;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [63:0] board_data;
    logic        board_valid;
    logic        board_ready;
    logic [7:0]  frame_count;
    logic [3:0]  err_count;
`ifdef BOARD_ECHO_EN
    logic [7:0]  echo_data;
    logic        echo_valid;
`endif

    always #5 clk = ~clk;

    jtag_board_loader #(.TIMEOUT_CYCLES(T)) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .board_data  (board_data),
        .board_valid (board_valid),
        .board_ready (board_ready),
        .frame_count (frame_count),
        .err_count   (err_count)
`ifdef BOARD_ECHO_EN
        ,
        .echo_data   (echo_data),
        .echo_valid  (echo_valid)
`endif
    );

    int checks = 0;
    int failures = 0;

    // Behavioural model: phase 0 idle, 1 collecting, 2 holding a finished board.
    int          m_phase, m_cnt, m_idle, m_frames, m_errs;
    logic [63:0] m_cells, m_board;
    logic        m_valid, m_echo_v;
    logic [7:0]  m_echo_d;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_set(input string set, input logic [7:0] b);
        for (int i = 0; i < set.len(); i++) begin
            if (set[i] == b) return 1'b1;
        end
        return 1'b0;
    endfunction

    // 0 alive, 1 dead, 2 skip, 3 abort, 4 illegal
    function automatic int kind(input logic [7:0] b);
        if (in_set("1#Oo", b)) return 0;
        if (in_set("0.", b)) return 1;
        if (in_set("\n\r ", b)) return 2;
        if (b == 8'h1B) return 3;
        return 4;
    endfunction

    task automatic bump_err();
        if (m_errs < 15) m_errs++;
    endtask

    task automatic model_update(input logic rst, input logic [7:0] d, input logic v, input logic br);
        int k;
        m_echo_v = 1'b0;
        m_echo_d = 8'd0;
        if (rst) begin
            m_phase = 0; m_cnt = 0; m_idle = 0; m_frames = 0; m_errs = 0;
            m_board = 64'd0; m_valid = 1'b0;
        end else if (m_phase == 2) begin
            if (br) begin
                m_valid = 1'b0;
                m_phase = 0;
            end
        end else if (v) begin
            k = kind(d);
            m_idle = 0;
            if (k <= 1) begin
                m_cells[m_cnt] = (k == 0);
                m_cnt++;
                m_phase = 1;
                m_echo_v = 1'b1;
                m_echo_d = (k == 0) ? 8'h23 : 8'h2E;
                if (m_cnt == 64) begin
                    m_board = m_cells;
                    m_valid = 1'b1;
                    m_frames = (m_frames + 1) % 256;
                    m_phase = 2;
                    m_cnt = 0;
                end
            end else if (k == 2) begin
                m_echo_v = 1'b1;
                m_echo_d = d;
            end else begin
                if (k == 4) begin
                    bump_err();
                    m_echo_v = 1'b1;
                    m_echo_d = 8'h3F;
                end
                m_phase = 0;
                m_cnt = 0;
            end
        end else if (m_phase == 1) begin
            m_idle++;
            if (m_idle == T) begin
                bump_err();
                m_phase = 0; m_cnt = 0; m_idle = 0;
                m_echo_v = 1'b1;
                m_echo_d = 8'h3F;
            end
        end
    endtask

    task automatic step(input logic rst, input logic [7:0] d, input logic v, input logic br);
        @(negedge clk);
        reset = rst; rx_data = d; rx_valid = v; board_ready = br;
        #1;
        check("rx_ready_pre", rx_ready, !rst && (m_phase != 2));
        model_update(rst, d, v, br);
        @(posedge clk);
        #1;
        check("rx_ready", rx_ready, !rst && (m_phase != 2));
        check("board_valid", board_valid, m_valid);
        check("board_data", board_data, m_board);
        check("frame_count", frame_count, m_frames[7:0]);
        check("err_count", err_count, m_errs[3:0]);
`ifdef BOARD_ECHO_EN
        check("echo_valid", echo_valid, m_echo_v);
        if (m_echo_v) check("echo_data", echo_data, m_echo_d);
`endif
    endtask

    task automatic send_byte(input logic [7:0] b);
        step(1'b0, b, 1'b1, 1'b0);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic send_cells(input int n, input logic [7:0] c);
        for (int i = 0; i < n; i++) send_byte(c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic release_board();
        step(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    string rows[8];
    int    burst;
    int    r;
    logic [7:0] b;
    string alive_s, dead_s, skip_s, bad_s;

    initial begin
        reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; board_ready = 1'b0;
        m_cells = 64'd0;
        model_update(1'b1, 8'h00, 1'b0, 1'b0);

        // Reset state
        step(1'b1, 8'h31, 1'b1, 1'b0);
        step(1'b1, 8'h31, 1'b1, 1'b0);
        check("rst_board", board_data, 64'd0);
        check("rst_valid", board_valid, 1'b0);
        check("rst_frames", frame_count, 8'd0);
        check("rst_errs", err_count, 4'd0);
        check("rst_rx_ready", rx_ready, 1'b0);
        idle(1);
        check("rx_ready_after_rst", rx_ready, 1'b1);

        // Glider with CR/LF between rows
        rows = '{"..#.....", "#.#.....", ".##.....", "........",
                 "........", "........", "........", "........"};
        for (int i = 0; i < 8; i++) begin
            send_str(rows[i]);
            if (i < 7) send_str("\r\n");
        end
        check("glider_valid", board_valid, 1'b1);
        check("glider_data", board_data, 64'h0000_0000_0006_0504);
        check("glider_frames", frame_count, 8'd1);

        // Backpressure: bytes offered while holding are refused
        for (int i = 0; i < 10; i++) begin
            send_byte(8'h31);
            check("bp_rx_ready", rx_ready, 1'b0);
            check("bp_data_stable", board_data, 64'h0000_0000_0006_0504);
        end
        release_board();
        check("bp_valid_drop", board_valid, 1'b0);
        check("bp_rx_ready_back", rx_ready, 1'b1);

        // Illegal byte mid-frame, then an all-alive frame
        send_cells(20, "1");
        send_byte("x");
        check("illegal_err", err_count, 4'd1);
        send_cells(64, "1");
        check("all_ones", board_data, 64'hFFFF_FFFF_FFFF_FFFF);
        check("all_ones_frames", frame_count, 8'd2);
        release_board();

        // Timeout expiry after T idle cycles, and survival with a byte on the last gap cycle
        send_cells(5, "O");
        idle(T - 1);
        check("to_not_yet", err_count, 4'd1);
        idle(1);
        check("to_expired", err_count, 4'd2);
        send_cells(5, "#");
        idle(T - 1);
        send_byte("o");
        check("to_survive", err_count, 4'd2);
        send_cells(58, ".");
        check("to_frame_valid", board_valid, 1'b1);
        check("to_frame_data", board_data, 64'h0000_0000_0000_003F);
        check("to_frame_count", frame_count, 8'd3);
        release_board();

        // ESC drops silently; reset mid-frame clears everything
        send_cells(30, "1");
        send_byte(8'h1B);
        check("esc_err", err_count, 4'd2);
        send_cells(10, "1");
        step(1'b1, 8'h31, 1'b1, 1'b0);
        check("midrst_board", board_data, 64'd0);
        check("midrst_frames", frame_count, 8'd0);
        check("midrst_errs", err_count, 4'd0);
        check("midrst_valid", board_valid, 1'b0);
        for (int i = 0; i < 32; i++) send_str("10");
        check("alt_board", board_data, 64'h5555_5555_5555_5555);
        check("alt_frames", frame_count, 8'd1);
        release_board();

`ifdef BOARD_ECHO_EN
        send_byte("1");
        check("echo1_v", echo_valid, 1'b1);
        check("echo1_d", echo_data, 8'h23);
        send_byte(".");
        check("echo2_d", echo_data, 8'h2E);
        send_byte(8'h0D);
        check("echo3_d", echo_data, 8'h0D);
        send_byte("Z");
        check("echo4_d", echo_data, 8'h3F);
        idle(1);
        check("echo_quiet", echo_valid, 1'b0);
`endif

        // Randomized traffic
        alive_s = "1#Oo"; dead_s = "0."; skip_s = "\n\r "; bad_s = "xZ?A";
        burst = 0;
        for (int i = 0; i < 4000; i++) begin
            if (burst > 0) begin
                burst--;
                step(1'b0, 8'h00, 1'b0, ($urandom_range(0, 3) == 0));
            end else if ($urandom_range(0, 1499) == 0) begin
                step(1'b1, 8'h00, 1'b0, 1'b0);
            end else begin
                r = $urandom_range(0, 99);
                if (r < 40)      b = alive_s[$urandom_range(0, 3)];
                else if (r < 82) b = dead_s[$urandom_range(0, 1)];
                else if (r < 93) b = skip_s[$urandom_range(0, 2)];
                else if (r < 95) b = 8'h1B;
                else if (r < 97) b = bad_s[$urandom_range(0, 3)];
                else begin
                    b = 8'h00;
                    burst = $urandom_range(5, 12);
                end
                step(1'b0, b, (burst == 0) && ($urandom_range(0, 9) < 8),
                     ($urandom_range(0, 3) == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
